// File: rtl/iopad_seq_pkg.sv
// Shared types and defaults for the IO pad ring output-enable sequencer.
package iopad_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    ON,
    RAMPDOWN
  } state_t;

  localparam int DEF_N_GROUPS = 4;
  localparam int DEF_SETTLE   = 16;
  localparam int SYNC_STAGES  = 2;

endpackage

// File: rtl/iopad_sync2.sv
// Multi-flop synchronizer (SYNC_STAGES deep) with synchronous reset, used for pwr_good.
module iopad_sync2
  import iopad_seq_pkg::*;
(
  input  logic ck,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge ck) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], d};
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/iopad_ring_seq.sv
// Staggered pad-group output-enable sequencer gated by synchronized power-good.
// Define IOPAD_SEQ_RAMPDOWN_EN to turn groups off one at a time on request withdrawal.
module iopad_ring_seq
  import iopad_seq_pkg::*;
#(
  parameter int N_GROUPS = DEF_N_GROUPS,
  parameter int SETTLE   = DEF_SETTLE
) (
  input  logic                ck,
  input  logic                rst,
  input  logic                pwr_good,
  input  logic                en_req,
  output logic [N_GROUPS-1:0] grp_oe,
  output logic                seq_busy,
  output logic                seq_done,
  output logic                fault
);

  localparam int CNT_W = $clog2(SETTLE + 1);
  localparam int IDX_W = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_GROUPS - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_GROUPS-1:0] oe_q, oe_d;
  logic                fault_q, fault_d;
  logic                pg_s;
  logic                go;

  iopad_sync2 u_pg_sync (
    .ck  (ck),
    .rst (rst),
    .d   (pwr_good),
    .q   (pg_s)
  );

  assign go = en_req & pg_s & ~fault_q;

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      oe_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      oe_q    <= oe_d;
      fault_q <= fault_d;
    end
  end

  // Enables are a thermometer code from bit 0, so shifting adds/removes the top group.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    oe_d    = oe_q;
    fault_d = fault_q;

    if (state_q != IDLE && !pg_s) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      oe_d    = '0;
      fault_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          oe_d = '0;
          if (!en_req) fault_d = 1'b0;
          if (go) begin
            state_d = RAMP;
            idx_d   = '0;
            oe_d    = N_GROUPS'(1);
            cnt_d   = CNT_LOAD;
          end
        end
        RAMP, ON: begin
          if (!en_req) begin
`ifdef IOPAD_SEQ_RAMPDOWN_EN
            oe_d    = oe_q >> 1;
            cnt_d   = CNT_LOAD;
            state_d = ((oe_q >> 1) == '0) ? IDLE : RAMPDOWN;
`else
            oe_d    = '0;
            cnt_d   = '0;
            state_d = IDLE;
`endif
          end else if (state_q == RAMP) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else if (idx_q == IDX_LAST) begin
              state_d = ON;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              oe_d  = (oe_q << 1) | N_GROUPS'(1);
              cnt_d = CNT_LOAD;
            end
          end
        end
`ifdef IOPAD_SEQ_RAMPDOWN_EN
        RAMPDOWN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            oe_d  = oe_q >> 1;
            cnt_d = CNT_LOAD;
            if ((oe_q >> 1) == '0) state_d = IDLE;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          oe_d    = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign grp_oe   = oe_q;
  assign seq_busy = (state_q == RAMP) || (state_q == RAMPDOWN);
  assign seq_done = (state_q == ON);
  assign fault    = fault_q;

endmodule

// File: tb/tb_iopad_ring_seq.sv
// Self-checking bench: spec-timed vector table, hand sequences and a randomized run
// against a behavioural model; two instances (SETTLE=16 and SETTLE=1) share stimulus.
`timescale 1ns/1ps
module tb_iopad_ring_seq;

  localparam int N = 4;
`ifdef IOPAD_SEQ_RAMPDOWN_EN
  localparam bit RAMPDOWN_ON = 1'b1;
`else
  localparam bit RAMPDOWN_ON = 1'b0;
`endif

  localparam int P_IDLE = 0;
  localparam int P_UP   = 1;
  localparam int P_ON   = 2;
  localparam int P_DOWN = 3;

  logic         ck = 1'b0;
  logic         rst, pwr_good, en_req;
  logic [N-1:0] oe_a, oe_b;
  logic         busy_a, done_a, flt_a, busy_b, done_b, flt_b;

  int tests = 0;
  int fails = 0;

  always #5 ck = ~ck;

  iopad_ring_seq #(.N_GROUPS(N), .SETTLE(16)) dut (
    .ck(ck), .rst(rst), .pwr_good(pwr_good), .en_req(en_req),
    .grp_oe(oe_a), .seq_busy(busy_a), .seq_done(done_a), .fault(flt_a)
  );

  iopad_ring_seq #(.N_GROUPS(N), .SETTLE(1)) dut_s1 (
    .ck(ck), .rst(rst), .pwr_good(pwr_good), .en_req(en_req),
    .grp_oe(oe_b), .seq_busy(busy_b), .seq_done(done_b), .fault(flt_b)
  );

  // Behavioural model: counts groups on and edges until the next step.
  typedef struct {
    int n_on;
    int phase;
    int wait_left;
    bit flt;
    bit pg_d1;
    bit pg_d2;
  } mdl_t;

  mdl_t m16, m1;

  function automatic mdl_t model_step(mdl_t m, bit r, bit en, bit pg, int settle);
    mdl_t n = m;
    bit   pgs = m.pg_d2;
    n.pg_d2 = m.pg_d1;
    n.pg_d1 = pg;
    if (r) begin
      n.n_on = 0; n.phase = P_IDLE; n.wait_left = 0; n.flt = 1'b0;
      n.pg_d1 = 1'b0; n.pg_d2 = 1'b0;
    end else if (m.phase != P_IDLE && !pgs) begin
      n.n_on = 0; n.phase = P_IDLE; n.flt = 1'b1;
    end else if (m.phase == P_IDLE) begin
      if (!en) n.flt = 1'b0;
      if (en && pgs && !m.flt) begin
        n.phase = P_UP; n.n_on = 1; n.wait_left = settle;
      end
    end else if ((m.phase == P_UP || m.phase == P_ON) && !en) begin
      if (RAMPDOWN_ON) begin
        n.n_on = m.n_on - 1;
        n.wait_left = settle;
        n.phase = (n.n_on == 0) ? P_IDLE : P_DOWN;
      end else begin
        n.n_on = 0; n.phase = P_IDLE;
      end
    end else if (m.phase == P_UP) begin
      n.wait_left = m.wait_left - 1;
      if (n.wait_left == 0) begin
        if (m.n_on == N) n.phase = P_ON;
        else begin n.n_on = m.n_on + 1; n.wait_left = settle; end
      end
    end else if (m.phase == P_DOWN) begin
      n.wait_left = m.wait_left - 1;
      if (n.wait_left == 0) begin
        n.n_on = m.n_on - 1;
        n.wait_left = settle;
        if (n.n_on == 0) n.phase = P_IDLE;
      end
    end
    return n;
  endfunction

  function automatic logic [N-1:0] thermo(int k);
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) if (i < k) v[i] = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string name,
                             input logic [N-1:0] oe, input logic busy, input logic done, input logic flt,
                             input logic [N-1:0] e_oe, input logic e_busy, input logic e_done, input logic e_flt);
    tests++;
    if ({oe, busy, done, flt} !== {e_oe, e_busy, e_done, e_flt}) begin
      fails++;
      $display("[TB] FAIL %s @%0t: got oe=%b busy=%b done=%b fault=%b, want oe=%b busy=%b done=%b fault=%b",
               name, $time, oe, busy, done, flt, e_oe, e_busy, e_done, e_flt);
    end
  endtask

  task automatic checkModel(input mdl_t m, input string name,
                            input logic [N-1:0] oe, input logic busy, input logic done, input logic flt);
    checkOutput(name, oe, busy, done, flt, thermo(m.n_on),
                (m.phase == P_UP) || (m.phase == P_DOWN), m.phase == P_ON, m.flt);
  endtask

  // One clock: model advances on the edge, both DUTs compared at the falling edge.
  task automatic tick();
    @(posedge ck);
    m16 = model_step(m16, rst, en_req, pwr_good, 16);
    m1  = model_step(m1,  rst, en_req, pwr_good, 1);
    @(negedge ck);
    checkModel(m16, "model_s16", oe_a, busy_a, done_a, flt_a);
    checkModel(m1,  "model_s1",  oe_b, busy_b, done_b, flt_b);
  endtask

  typedef struct {
    string        name;
    bit           r;
    bit           pg;
    bit           en;
    int           cycles;
    logic [N-1:0] oe;
    bit           busy;
    bit           done;
    bit           flt;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(string name, bit r, bit pg, bit en, int cycles,
                                 logic [N-1:0] oe, bit busy, bit done, bit flt);
    vec_t v;
    v.name = name; v.r = r; v.pg = pg; v.en = en; v.cycles = cycles;
    v.oe = oe; v.busy = busy; v.done = done; v.flt = flt;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input bit r, input bit pg, input bit en, input int cycles);
    rst = r; pwr_good = pg; en_req = en;
    repeat (cycles) tick();
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    rst = 1'b0;
  endtask

  logic [N-1:0] dn_exp [4];
  bit           found;

  initial begin
    rst = 1'b1; pwr_good = 1'b0; en_req = 1'b0;
    m16 = '{0, P_IDLE, 0, 1'b0, 1'b0, 1'b0};
    m1  = m16;

    // Nominal ramp (edges counted from pwr_good/en_req rising), then mid-ramp power loss.
    addVec("reset",        1, 0, 0,  2, 4'b0000, 0, 0, 0);
    addVec("sync_e2",      0, 1, 1,  2, 4'b0000, 0, 0, 0);
    addVec("g0_e3",        0, 1, 1,  1, 4'b0001, 1, 0, 0);
    addVec("g0_e18",       0, 1, 1, 15, 4'b0001, 1, 0, 0);
    addVec("g1_e19",       0, 1, 1,  1, 4'b0011, 1, 0, 0);
    addVec("g2_e35",       0, 1, 1, 16, 4'b0111, 1, 0, 0);
    addVec("g3_e51",       0, 1, 1, 16, 4'b1111, 1, 0, 0);
    addVec("busy_e66",     0, 1, 1, 15, 4'b1111, 1, 0, 0);
    addVec("done_e67",     0, 1, 1,  1, 4'b1111, 0, 1, 0);
    addVec("on_hold",      0, 1, 1, 10, 4'b1111, 0, 1, 0);
    addVec("reset2",       1, 0, 0,  2, 4'b0000, 0, 0, 0);
    addVec("g0_again",     0, 1, 1,  3, 4'b0001, 1, 0, 0);
    addVec("g2_again",     0, 1, 1, 32, 4'b0111, 1, 0, 0);
    addVec("pre_loss_e40", 0, 1, 1,  5, 4'b0111, 1, 0, 0);
    addVec("loss_e42",     0, 0, 1,  2, 4'b0111, 1, 0, 0);
    addVec("loss_e43",     0, 0, 1,  1, 4'b0000, 0, 0, 1);
    addVec("fault_block",  0, 1, 1,  8, 4'b0000, 0, 0, 1);
    addVec("fault_clear",  0, 1, 0,  1, 4'b0000, 0, 0, 0);
    addVec("restart",      0, 1, 1,  1, 4'b0001, 1, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].pg, vecs[i].en, vecs[i].cycles);
      checkOutput(vecs[i].name, oe_a, busy_a, done_a, flt_a,
                  vecs[i].oe, vecs[i].busy, vecs[i].done, vecs[i].flt);
    end

    // Withdrawal from ON: immediate off, or one group per 16 edges with ramp-down.
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b1, 70);
    checkOutput("on_before_wd", oe_a, busy_a, done_a, flt_a, 4'b1111, 1'b0, 1'b1, 1'b0);
    if (RAMPDOWN_ON) begin
      dn_exp[0] = 4'b0111; dn_exp[1] = 4'b0011; dn_exp[2] = 4'b0001; dn_exp[3] = 4'b0000;
    end else begin
      dn_exp[0] = 4'b0000; dn_exp[1] = 4'b0000; dn_exp[2] = 4'b0000; dn_exp[3] = 4'b0000;
    end
    en_req = 1'b0;
    tick();
    checkOutput("wd_step0", oe_a, busy_a, done_a, flt_a, dn_exp[0], RAMPDOWN_ON, 1'b0, 1'b0);
    for (int k = 1; k < 4; k++) begin
      repeat (16) tick();
      checkOutput("wd_step", oe_a, busy_a, done_a, flt_a, dn_exp[k], (k < 3) && RAMPDOWN_ON, 1'b0, 1'b0);
    end

    // Power loss reaching pg_s on the same edge as en_req falls: power loss wins.
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b1, 70);
    applyStimulus(1'b0, 1'b0, 1'b1, 2);
    checkOutput("simul_pre", oe_a, busy_a, done_a, flt_a, 4'b1111, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("simul_edge", oe_a, busy_a, done_a, flt_a, 4'b0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3);
    checkOutput("simul_after", oe_a, busy_a, done_a, flt_a, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Reset mid-ramp at 0011, and the SETTLE=1 instance stepping every edge.
    resetDut();
    pwr_good = 1'b1; en_req = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      tick();
      if (oe_a == 4'b0011) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("[TB] FAIL wait_0011: got oe=%b, want 0011 within 100 cycles", oe_a);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    checkOutput("rst_mid_s16", oe_a, busy_a, done_a, flt_a, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_mid_s1",  oe_b, busy_b, done_b, flt_b, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 2);
    checkOutput("s1_sync", oe_b, busy_b, done_b, flt_b, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= N; k++) begin
      tick();
      checkOutput("s1_step", oe_b, busy_b, done_b, flt_b, thermo(k), 1'b1, 1'b0, 1'b0);
    end
    tick();
    checkOutput("s1_done", oe_b, busy_b, done_b, flt_b, 4'b1111, 1'b0, 1'b1, 1'b0);

    // Randomized segments, both instances checked against the model every cycle.
    for (int s = 0; s < 150; s++) begin
      int len;
      bit r;
      len = $urandom_range(1, 40);
      r   = ($urandom_range(0, 24) == 0);
      if (r) len = 1;
      applyStimulus(r, $urandom_range(0, 5) != 0, $urandom_range(0, 3) != 0, len);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
